// File: rtl/writeback_stage.sv
// Registered write-back stage: source select, load extraction, x0 suppression,
// a 2-entry skid buffer toward the register file and a retired-instruction counter.
module writeback_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_WIDTH-1:0]     instruction_address,
    input  logic [DATA_WIDTH-1:0]     alu_result,
    input  logic [DATA_WIDTH-1:0]     memory_read_data,
    input  logic [DATA_WIDTH-1:0]     csr_read_data,
    input  logic [1:0]                regs_write_source,
    input  logic [2:0]                mem_funct3,
    input  logic                      regs_write_enable,
    input  logic [REG_ADDR_WIDTH-1:0] regs_write_address,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      rf_write_enable,
    output logic [REG_ADDR_WIDTH-1:0] rf_write_address,
    output logic [DATA_WIDTH-1:0]     rf_write_data,
    output logic [CNT_WIDTH-1:0]      retire_count
);

    localparam int OFF_W = $clog2(DATA_WIDTH / 8);
    localparam logic [OFF_W-1:0] HALF_MASK = ~OFF_W'(1);
    localparam logic [OFF_W-1:0] WORD_MASK = ~OFF_W'(3);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;

    logic [OFF_W-1:0]          w_off;
    logic [OFF_W-1:0]          w_off_half;
    logic [OFF_W-1:0]          w_off_word;
    logic [7:0]                w_byte;
    logic [15:0]               w_half;
    logic [31:0]               w_word;
    logic [DATA_WIDTH-1:0]     w_load;
    logic [ADDR_WIDTH-1:0]     w_pc4;
    logic [DATA_WIDTH-1:0]     w_sel_data;
    logic                      w_sel_we;

    logic                      w_accept;
    logic                      w_drain;
    logic                      w_load_head;
    logic                      w_load_skid;
    logic                      w_skid_to_head;

    logic                      r_in_ready;
    logic                      r_head_we;
    logic [REG_ADDR_WIDTH-1:0] r_head_addr;
    logic [DATA_WIDTH-1:0]     r_head_data;
    logic                      r_skid_we;
    logic [REG_ADDR_WIDTH-1:0] r_skid_addr;
    logic [DATA_WIDTH-1:0]     r_skid_data;
    logic [CNT_WIDTH-1:0]      r_retire;

    // Misaligned offsets are rounded down to the access size.
    assign w_off      = alu_result[OFF_W-1:0];
    assign w_off_half = w_off & HALF_MASK;
    assign w_off_word = w_off & WORD_MASK;
    assign w_byte     = 8'(memory_read_data >> {w_off, 3'b000});
    assign w_half     = 16'(memory_read_data >> {w_off_half, 3'b000});
    assign w_word     = 32'(memory_read_data >> {w_off_word, 3'b000});

    // On a 32-bit datapath a sign-extended word is the raw word, so 3/6/7 collapse to LW.
    always_comb begin
        case (mem_funct3)
            3'd0:    w_load = DATA_WIDTH'($signed(w_byte));
            3'd1:    w_load = DATA_WIDTH'($signed(w_half));
            3'd2:    w_load = DATA_WIDTH'($signed(w_word));
            3'd4:    w_load = DATA_WIDTH'(w_byte);
            3'd5:    w_load = DATA_WIDTH'(w_half);
            3'd6:    w_load = (DATA_WIDTH == 64) ? DATA_WIDTH'(w_word) : memory_read_data;
            default: w_load = memory_read_data;
        endcase
    end

    assign w_pc4 = instruction_address + ADDR_WIDTH'(4);

    always_comb begin
        case (regs_write_source)
            2'd0:    w_sel_data = alu_result;
            2'd1:    w_sel_data = w_load;
            2'd2:    w_sel_data = csr_read_data;
            default: w_sel_data = DATA_WIDTH'(w_pc4);
        endcase
    end

    assign w_sel_we = regs_write_enable && (regs_write_address != '0);

    assign w_accept = in_valid && r_in_ready;
    assign w_drain  = (r_state != EMPTY) && out_ready;

    always_comb begin
        w_next_state   = r_state;
        w_load_head    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_head = 1'b0;
        if (flush) begin
            w_next_state = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_next_state = ONE;
                        w_load_head  = 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && !w_drain) begin
                        w_next_state = TWO;
                        w_load_skid  = 1'b1;
                    end else if (!w_accept && w_drain) begin
                        w_next_state = EMPTY;
                    end else if (w_accept && w_drain) begin
                        w_load_head  = 1'b1;
                    end
                end
                TWO: begin
                    if (w_drain) begin
                        w_next_state   = ONE;
                        w_skid_to_head = 1'b1;
                    end
                end
                default: w_next_state = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
            r_retire   <= '0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != TWO);
            if (w_drain) begin
                r_retire <= r_retire + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head_we   <= 1'b0;
            r_head_addr <= '0;
            r_head_data <= '0;
            r_skid_we   <= 1'b0;
            r_skid_addr <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_load_head) begin
                r_head_we   <= w_sel_we;
                r_head_addr <= regs_write_address;
                r_head_data <= w_sel_data;
            end else if (w_skid_to_head) begin
                r_head_we   <= r_skid_we;
                r_head_addr <= r_skid_addr;
                r_head_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_we   <= w_sel_we;
                r_skid_addr <= regs_write_address;
                r_skid_data <= w_sel_data;
            end
        end
    end

    assign in_ready         = r_in_ready;
    assign out_valid        = (r_state != EMPTY);
    assign rf_write_enable  = out_valid && r_head_we;
    assign rf_write_address = r_head_addr;
    assign rf_write_data    = r_head_data;
    assign retire_count     = r_retire;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage (32-bit datapath): expected entries are queued
// at acceptance and compared when the head drains.
module tb_writeback_stage;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction_address;
    logic [31:0] alu_result;
    logic [31:0] memory_read_data;
    logic [31:0] csr_read_data;
    logic [1:0]  regs_write_source;
    logic [2:0]  mem_funct3;
    logic        regs_write_enable;
    logic [4:0]  regs_write_address;
    logic        out_valid;
    logic        out_ready;
    logic        rf_write_enable;
    logic [4:0]  rf_write_address;
    logic [31:0] rf_write_data;
    logic [63:0] retire_count;

    writeback_stage #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .REG_ADDR_WIDTH(5),
        .CNT_WIDTH     (64)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .flush              (flush),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .instruction_address(instruction_address),
        .alu_result         (alu_result),
        .memory_read_data   (memory_read_data),
        .csr_read_data      (csr_read_data),
        .regs_write_source  (regs_write_source),
        .mem_funct3         (mem_funct3),
        .regs_write_enable  (regs_write_enable),
        .regs_write_address (regs_write_address),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .rf_write_enable    (rf_write_enable),
        .rf_write_address   (rf_write_address),
        .rf_write_data      (rf_write_data),
        .retire_count       (retire_count)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    entry_t      sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [63:0] exp_cnt = '0;
    logic        stall_prev = 1'b0;
    entry_t      head_prev;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_data(input logic [1:0] src, input logic [2:0] f3,
                                               input logic [31:0] alu, input logic [31:0] mem,
                                               input logic [31:0] csr, input logic [31:0] pc);
        logic [7:0]  b;
        logic [15:0] h;
        case (alu[1:0])
            2'd0:    b = mem[7:0];
            2'd1:    b = mem[15:8];
            2'd2:    b = mem[23:16];
            default: b = mem[31:24];
        endcase
        h = alu[1] ? mem[31:16] : mem[15:0];
        case (src)
            2'd0: return alu;
            2'd2: return csr;
            2'd3: return pc + 32'd4;
            default: begin
                case (f3)
                    3'd0:    return {{24{b[7]}}, b};
                    3'd1:    return {{16{h[15]}}, h};
                    3'd4:    return {24'd0, b};
                    3'd5:    return {16'd0, h};
                    default: return mem;
                endcase
            end
        endcase
    endfunction

    // Inputs change at posedge+1 only, so the negedge view is exactly what the next edge uses.
    always @(negedge clock) begin
        entry_t e;
        entry_t cur;
        if (!reset) begin
            cur = '{we: rf_write_enable, addr: rf_write_address, data: rf_write_data};
            check("occupancy", {63'd0, out_valid}, {63'd0, sb_q.size() != 0});
            check("in_ready", {63'd0, in_ready}, {63'd0, sb_q.size() < 2});
            check("retire", retire_count, exp_cnt);
            if (stall_prev) check("stall_stable", {31'd0, cur}, {31'd0, head_prev});
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("underflow", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("drain_we", {63'd0, rf_write_enable}, {63'd0, e.we});
                    check("drain_addr", {59'd0, rf_write_address}, {59'd0, e.addr});
                    check("drain_data", {32'd0, rf_write_data}, {32'd0, e.data});
                end
                exp_cnt = exp_cnt + 64'd1;
            end
            if (flush) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                e.we   = regs_write_enable && (regs_write_address != 5'd0);
                e.addr = regs_write_address;
                e.data = model_data(regs_write_source, mem_funct3, alu_result,
                                    memory_read_data, csr_read_data, instruction_address);
                sb_q.push_back(e);
            end
            stall_prev = out_valid && !out_ready && !flush;
            head_prev  = cur;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] src, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] csr, input logic [31:0] pc,
                         input logic we, input logic [4:0] wa);
        regs_write_source   = src;
        mem_funct3          = f3;
        alu_result          = alu;
        memory_read_data    = mem;
        csr_read_data       = csr;
        instruction_address = pc;
        regs_write_enable   = we;
        regs_write_address  = wa;
        in_valid            = 1'b1;
    endtask

    // Called at posedge+1 from an empty buffer with out_ready=1; returns at posedge+1.
    task automatic single(input string tag, input logic [1:0] src, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] csr,
                          input logic [31:0] pc, input logic [31:0] exp);
        drive(src, f3, alu, mem, csr, pc, 1'b1, 5'd7);
        step();
        in_valid = 1'b0;
        @(negedge clock);
        check(tag, {32'd0, rf_write_data}, {32'd0, exp});
        step();
    endtask

    task automatic wait_empty(input string tag);
        int unsigned k;
        for (k = 0; k < 20; k++) begin
            @(negedge clock);
            if (!out_valid) break;
        end
        if (k == 20) check(tag, 64'd0, 64'd1);
        step();
    endtask

    initial begin
        logic [63:0] base;
        bit          took;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(2'd0, 3'd0, '0, '0, '0, '0, 1'b0, 5'd0);
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_retire", retire_count, 64'd0);
        check("rst_data", {32'd0, rf_write_data}, 64'd0);
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        step();

        single("lb",    2'd1, 3'd0, 32'h0000_0002, 32'h80FF_7F01, '0, '0, 32'hFFFF_FFFF);
        single("lbu",   2'd1, 3'd4, 32'h0000_0002, 32'h80FF_7F01, '0, '0, 32'h0000_00FF);
        single("lh2",   2'd1, 3'd1, 32'h0000_0002, 32'h80FF_7F01, '0, '0, 32'hFFFF_80FF);
        single("lhu3",  2'd1, 3'd5, 32'h0000_0003, 32'h80FF_7F01, '0, '0, 32'h0000_80FF);
        single("lb0",   2'd1, 3'd0, 32'h0000_0000, 32'h80FF_7F01, '0, '0, 32'h0000_0001);
        single("lw3",   2'd1, 3'd2, 32'h0000_0003, 32'h80FF_7F01, '0, '0, 32'h80FF_7F01);
        single("f3_7",  2'd1, 3'd7, 32'h0000_0001, 32'h1234_5678, '0, '0, 32'h1234_5678);
        single("f3_6",  2'd1, 3'd6, 32'h0000_0002, 32'h8765_4321, '0, '0, 32'h8765_4321);
        single("pc4",   2'd3, 3'd0, '0, '0, '0, 32'hFFFF_FFFC, 32'h0000_0000);
        single("csr",   2'd2, 3'd0, '0, '0, 32'h0000_1234, '0, 32'h0000_1234);
        single("alu",   2'd0, 3'd0, 32'hDEAD_BEEF, '0, '0, '0, 32'hDEAD_BEEF);

        base = exp_cnt;
        drive(2'd0, 3'd0, 32'h55, '0, '0, '0, 1'b1, 5'd0);
        step();
        in_valid = 1'b0;
        @(negedge clock);
        check("x0_valid", {63'd0, out_valid}, 64'd1);
        check("x0_we", {63'd0, rf_write_enable}, 64'd0);
        step();
        @(negedge clock);
        check("x0_retire", retire_count, base + 64'd1);
        step();

        // Backpressure: A and B fill the buffer, C waits upstream.
        out_ready = 1'b0;
        base = exp_cnt;
        drive(2'd0, 3'd0, 32'hA, '0, '0, '0, 1'b1, 5'd1);
        step();
        drive(2'd0, 3'd0, 32'hB, '0, '0, '0, 1'b1, 5'd2);
        step();
        drive(2'd0, 3'd0, 32'hC, '0, '0, '0, 1'b1, 5'd3);
        @(negedge clock);
        check("bp_full", {63'd0, in_ready}, 64'd0);
        check("bp_head", {32'd0, rf_write_data}, 64'hA);
        step();
        step();
        out_ready = 1'b1;
        took = 1'b0;
        for (int unsigned k = 0; k < 10 && !took; k++) begin
            @(negedge clock);
            took = in_ready;
            step();
        end
        if (!took) check("bp_accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        wait_empty("bp_drain_timeout");
        @(negedge clock);
        check("bp_retire", retire_count, base + 64'd3);
        step();

        // Flush in TWO with a pending input and no drain.
        out_ready = 1'b0;
        drive(2'd0, 3'd0, 32'h11, '0, '0, '0, 1'b1, 5'd4);
        step();
        drive(2'd0, 3'd0, 32'h22, '0, '0, '0, 1'b1, 5'd5);
        step();
        drive(2'd0, 3'd0, 32'h33, '0, '0, '0, 1'b1, 5'd6);
        flush = 1'b1;
        base = exp_cnt;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        check("flush_retire", retire_count, base);
        step();

        // Flush with a simultaneous drain: the head still retires.
        drive(2'd0, 3'd0, 32'h44, '0, '0, '0, 1'b1, 5'd8);
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        out_ready = 1'b1;
        base = exp_cnt;
        step();
        flush = 1'b0;
        @(negedge clock);
        check("flushd_valid", {63'd0, out_valid}, 64'd0);
        check("flushd_retire", retire_count, base + 64'd1);
        step();

        for (int unsigned k = 0; k < 80; k++) begin
            drive(2'($urandom), 3'($urandom), $urandom, $urandom, $urandom, $urandom,
                  1'($urandom), 5'($urandom_range(0, 3)));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_empty("rand_drain_timeout");

        // Asynchronous reset while holding two entries.
        out_ready = 1'b0;
        drive(2'd0, 3'd0, 32'h66, '0, '0, '0, 1'b1, 5'd9);
        step();
        drive(2'd0, 3'd0, 32'h77, '0, '0, '0, 1'b1, 5'd10);
        step();
        in_valid = 1'b0;
        check("pre_rst_full", {63'd0, in_ready}, 64'd0);
        #1;
        reset = 1'b1;
        #1;
        check("arst_valid", {63'd0, out_valid}, 64'd0);
        check("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check("arst_retire", retire_count, 64'd0);
        check("arst_we", {63'd0, rf_write_enable}, 64'd0);
        check("arst_addr", {59'd0, rf_write_address}, 64'd0);
        check("arst_data", {32'd0, rf_write_data}, 64'd0);
        sb_q.delete();
        exp_cnt = '0;
        step();
        reset = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Parametrised, registered successor to the combinational write-back mux.
- Accepts one instruction result per cycle over a valid/ready handshake and selects the register-file write data.
- Performs load byte/half/word extraction with sign or zero extension, and suppresses writes to x0.
- Presents the result to the register file through a 2-entry skid buffer and keeps a retired-instruction counter for the CSR unit.

Parameters:
- DATA_WIDTH, 32, register/data width. Legal values are 32 or 64.
- ADDR_WIDTH, 32, instruction address width.
- REG_ADDR_WIDTH, 5, register index width.
- CNT_WIDTH, 64, retired-instruction counter width.

Ports:
- clock  in  1  Single clock; all state updates on the rising edge.
- reset  in  1  Asynchronous, active-high.
- flush  in  1  Synchronous. Discards all buffered entries.
- in_valid  in  1  Upstream holds a valid instruction result.
- in_ready  out  1  Stage can accept an input this cycle.
- instruction_address  in  ADDR_WIDTH  PC of the instruction.
- alu_result  in  DATA_WIDTH  ALU output; also the load address for byte offset.
- memory_read_data  in  DATA_WIDTH  Raw aligned memory word.
- csr_read_data  in  DATA_WIDTH  CSR read value.
- regs_write_source  in  2  Source select: 0 ALU, 1 Memory, 2 CSR, 3 PC+4.
- mem_funct3  in  3  Load type: 0 LB, 1 LH, 2 LW, 3 LD (64-bit only), 4 LBU, 5 LHU, 6 LWU (64-bit only).
- regs_write_enable  in  1  Instruction writes a register.
- regs_write_address  in  REG_ADDR_WIDTH  Destination register.
- out_valid  out  1  Head entry is valid.
- out_ready  in  1  Register file or next consumer accepts the head entry.
- rf_write_enable  out  1  Qualified write enable.
- rf_write_address  out  REG_ADDR_WIDTH  Destination register of the head entry.
- rf_write_data  out  DATA_WIDTH  Selected write data of the head entry.
- retire_count  out  CNT_WIDTH  Count of retired instructions.

Behaviour:
- Reset (asynchronous, immediate):
  - All outputs are 0 except in_ready, which is 1.
  - Both buffer entries are invalid; retire_count is 0.
- Data select and extraction (combinational, before the register):
  - Source 0: alu_result.
  - Source 1: extracted load data.
  - Source 2: csr_read_data.
  - Source 3: instruction_address + 4, zero-extended or truncated to DATA_WIDTH, wrapping modulo 2^ADDR_WIDTH.
- Load extraction:
  - off = alu_result[log2(DATA_WIDTH/8)-1:0].
  - LB/LBU take the byte at off; LH/LHU take the halfword at off & ~1; LW/LWU take the word at off & ~3.
  - Signed types sign-extend to DATA_WIDTH; unsigned types zero-extend.
  - LD returns the full word.
  - With DATA_WIDTH=32, funct3 values 3, 6 and 7 act as LW. With DATA_WIDTH=64, funct3 7 acts as LD.
  - Misaligned offsets are silently rounded down; no trap.
- Write enable:
  - The stored write enable is regs_write_enable && (regs_write_address != 0).
  - rf_write_enable = out_valid && stored write enable.
- Buffer state machine: states EMPTY, ONE (head valid), TWO (head + skid valid).
  - in_ready = (state != TWO), registered, with no combinational path from out_ready.
  - Accept condition: in_valid && in_ready. Drain condition: out_valid && out_ready.
  - EMPTY + accept -> ONE. Latency is 1 cycle: data appears on the outputs the cycle after acceptance.
  - ONE: accept with no drain -> TWO (new entry goes to skid). Drain with no accept -> EMPTY. Accept and drain together -> ONE, head replaced by the new entry.
  - TWO: drain -> ONE (skid moves to head). Inputs are ignored because in_ready = 0.
- Outputs: head entry outputs stay stable while out_valid && !out_ready.
- Flush:
  - Next state is EMPTY; any same-cycle accept is dropped.
  - A drain in the same cycle as flush still completes and still counts toward retire_count.
- retire_count:
  - Increments by 1 on each drain, regardless of rf_write_enable.
  - Wraps at 2^CNT_WIDTH.
  - Reset clears it; flush does not.

Test Plan:
- Reset asserted mid-stream with state TWO -> outputs immediately 0, in_ready=1, retire_count=0 without waiting for a clock edge.
- Source 1, LB, memory_read_data=0x80FF7F01, alu_result=0x...2, out_ready=1 -> rf_write_data=0xFFFFFFFF one cycle later. Same input with LBU -> 0x000000FF. LH at off 2 -> 0xFFFF80FF.
- Source 3, instruction_address=0xFFFFFFFC -> rf_write_data=0x00000000 (wraps). Source 2, csr_read_data=0x1234 -> 0x1234.
- regs_write_enable=1 with regs_write_address=0 -> out_valid=1, rf_write_enable=0, retire_count still increments.
- Backpressure sequence:
  - out_ready=0; accept A then B -> state TWO, in_ready=0, C is held upstream.
  - out_ready=1 -> A, B, C drain in order, one per cycle, with head data unchanged while stalled.
  - retire_count = 3.
- Flush in state TWO while in_valid=1 and out_ready=0 -> state EMPTY next cycle, out_valid=0, retire_count unchanged.
- Flush with out_ready=1 -> the head entry counts as retired.
